nn_instr_fetch_issue: RTL and testbench

//  Instruction fetch/issue front end for the NN core. Walks a program counter over instruction

---
 rtl/nn_isa_pkg.sv | 44 ++++
 rtl/nn_issue_fifo.sv | 55 +++++
 rtl/nn_instr_fetch_issue.sv | 131 +++++++++++++
 tb/tb_nn_instr_fetch_issue.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_isa_pkg.sv
// NN core ISA definitions: opcodes, instruction field positions,
// opcode legality and the fetch front-end state encoding.
package nn_isa_pkg;

   localparam int INSTR_W = 16;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 8;
   localparam int RS_HI = 7;
   localparam int RS_LO = 4;
   localparam int RT_HI = 3;
   localparam int RT_LO = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_SLT  = 4'h3;
   localparam logic [3:0] OP_MAC  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hB;
   localparam logic [3:0] OP_LD   = 4'hE;
   localparam logic [3:0] OP_ST   = 4'hF;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RUN,
      FS_DRAIN,
      FS_HALTED
   } fetchState_t;

   function automatic logic opcode_legal(input logic [3:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_NOP, OP_ADD, OP_MUL, OP_SLT, OP_MAC,
         OP_ADDI, OP_HALT, OP_LD, OP_ST: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/nn_issue_fifo.sv
// Synchronous issue buffer with flush; head word is read
// combinationally from storage.
module nn_issue_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic             full;
   logic             empty;
   logic             doPush;
   logic             doPop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign doPop   = pop && !empty;
   assign doPush  = push && (!full || doPop);
   assign popData = store[rdPtr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         unique case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word storage, written at the tail.
   always_ff @(posedge clk) begin
      if (doPush) store[wrPtr] <= pushData;
   end

endmodule

// File: rtl/nn_instr_fetch_issue.sv
// NN core fetch/issue front end: PC walk, opcode check, issue buffer.
// Optional issue counter enabled by defining NN_ISSUE_CNT_EN.
module nn_instr_fetch_issue
   import nn_isa_pkg::*;
#(
   parameter int AW         = 8,
   parameter int BOOT_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               imem_en,
   output logic [AW-1:0]      imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [AW-1:0]      instr_pc,
   output logic               busy,
   output logic               halted,
   output logic               op_err
`ifdef NN_ISSUE_CNT_EN
   ,
   output logic [15:0]        issue_cnt
`endif
);

   localparam logic [AW-1:0] BOOT = AW'(BOOT_ADDR);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetchState_t          state;
   fetchState_t          stateNext;
   logic [AW-1:0]        pc;
   logic [AW-1:0]        inflightPc;
   logic                 inflight;
   logic                 opErr;
   logic                 startOk;
   logic                 fetchEn;
   logic                 retValid;
   logic                 retLegal;
   logic                 retHalt;
   logic                 push;
   logic                 pop;
   logic [CW-1:0]        fifoCount;
   logic [INSTR_W+AW-1:0] headWord;

   assign startOk  = start && (state == FS_IDLE || state == FS_HALTED);
   assign fetchEn  = (state == FS_RUN) &&
                     (int'(fifoCount) + int'(inflight) < FIFO_DEPTH);
   assign retValid = inflight && (state == FS_RUN);
   assign retLegal = opcode_legal(imem_rdata[OP_HI:OP_LO]);
   assign retHalt  = (imem_rdata[OP_HI:OP_LO] == OP_HALT);
   assign push     = retValid && retLegal;
   assign pop      = instr_valid && instr_ready;

   assign imem_en     = fetchEn;
   assign imem_addr   = pc;
   assign instr_valid = (fifoCount != '0);
   assign instr       = instr_valid ? headWord[INSTR_W+AW-1:AW] : '0;
   assign instr_pc    = instr_valid ? headWord[AW-1:0] : '0;
   assign busy        = (state == FS_RUN) || (state == FS_DRAIN);
   assign halted      = (state == FS_HALTED) && !opErr;
   assign op_err      = opErr;

   nn_issue_fifo #(
      .WIDTH (INSTR_W + AW),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (startOk),
      .push     (push),
      .pushData ({imem_rdata, inflightPc}),
      .pop      (pop),
      .popData  (headWord),
      .count    (fifoCount)
   );

   // Run-state transitions; DRAIN ends once the last buffered word leaves.
   always_comb begin
      stateNext = state;
      unique case (state)
         FS_IDLE:   if (start) stateNext = FS_RUN;
         FS_RUN:    if (retValid && (retHalt || !retLegal))
                       stateNext = FS_DRAIN;
         FS_DRAIN:  if (fifoCount == '0 ||
                        (fifoCount == CW'(1) && pop))
                       stateNext = FS_HALTED;
         FS_HALTED: if (start) stateNext = FS_RUN;
         default:   stateNext = FS_IDLE;
      endcase
   end

   // State, PC, in-flight tracking and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FS_IDLE;
         pc         <= BOOT;
         inflightPc <= BOOT;
         inflight   <= 1'b0;
         opErr      <= 1'b0;
      end else begin
         state <= stateNext;
         if (startOk) begin
            pc       <= BOOT;
            inflight <= 1'b0;
            opErr    <= 1'b0;
         end else begin
            if (fetchEn) begin
               pc         <= pc + 1'b1;
               inflightPc <= pc;
            end
            inflight <= fetchEn;
            if (retValid && !retLegal) opErr <= 1'b1;
         end
      end
   end

`ifdef NN_ISSUE_CNT_EN
   // Saturating count of issued words since the last start.
   always_ff @(posedge clk) begin
      if (!rst_n || startOk) begin
         issue_cnt <= '0;
      end else if (pop && issue_cnt != 16'hFFFF) begin
         issue_cnt <= issue_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nn_instr_fetch_issue.sv
// Self-checking bench for nn_instr_fetch_issue: directed scenarios
// plus random programs checked against a program-walk model.
module tb_nn_instr_fetch_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        busy;
   logic        halted;
   logic        op_err;
   logic [15:0] issueCnt;

   logic        wStart;
   logic        wEn;
   logic [3:0]  wAddr;
   logic [15:0] wRdata;
   logic        wValid;
   logic        wReady;
   logic [15:0] wInstr;
   logic [3:0]  wPc;
   logic        wBusy;
   logic        wHalted;
   logic        wErr;
   logic [15:0] wCnt;

   logic [15:0] mem [256];
   logic [15:0] wMem [16];

   logic [23:0] obsQ[$];
   logic [23:0] expQ[$];
   logic [3:0]  wObsQ[$];
   int          fetchCnt;
   int          maxAddr;
   logic        expHalt;
   logic        expErr;
   int          nChk = 0;
   int          nFail = 0;

   always #5 clk = ~clk;

   nn_instr_fetch_issue #(.AW(8), .BOOT_ADDR(0), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .busy        (busy),
      .halted      (halted),
      .op_err      (op_err)
`ifdef NN_ISSUE_CNT_EN
      ,
      .issue_cnt   (issueCnt)
`endif
   );

   nn_instr_fetch_issue #(.AW(4), .BOOT_ADDR(14), .FIFO_DEPTH(4)) dutW (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (wStart),
      .imem_en     (wEn),
      .imem_addr   (wAddr),
      .imem_rdata  (wRdata),
      .instr_valid (wValid),
      .instr_ready (wReady),
      .instr       (wInstr),
      .instr_pc    (wPc),
      .busy        (wBusy),
      .halted      (wHalted),
      .op_err      (wErr)
`ifdef NN_ISSUE_CNT_EN
      ,
      .issue_cnt   (wCnt)
`endif
   );

`ifndef NN_ISSUE_CNT_EN
   assign issueCnt = '0;
   assign wCnt     = '0;
`endif

   // Instruction memories: one-cycle read latency.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
      if (wEn)     wRdata     <= wMem[wAddr];
   end

   // Handshake and fetch monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (instr_valid && instr_ready) obsQ.push_back({instr, instr_pc});
      if (imem_en) begin
         fetchCnt = fetchCnt + 1;
         if (int'(imem_addr) > maxAddr) maxAddr = int'(imem_addr);
      end
      if (wValid && wReady) wObsQ.push_back(wPc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic isLegal(input logic [3:0] op);
      return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                        4'h9, 4'hB, 4'hE, 4'hF};
   endfunction

   // Expected issue stream: walk memory from address 0 until a HALT
   // (issued) or an illegal word (not issued).
   function automatic void buildModel();
      logic [7:0] a;
      expQ.delete();
      expHalt = 1'b0;
      expErr  = 1'b0;
      for (int k = 0; k < 256; k++) begin
         a = 8'(k);
         if (!isLegal(mem[a][15:12])) begin
            expErr = 1'b1;
            break;
         end
         expQ.push_back({mem[a], a});
         if (mem[a][15:12] == 4'hB) begin
            expHalt = 1'b1;
            break;
         end
      end
   endfunction

   function automatic logic [15:0] randLegal();
      logic [3:0] ops [8];
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hE, 4'hF};
      return {ops[$urandom_range(0, 7)], 12'($urandom)};
   endfunction

   task automatic startRun();
      obsQ.delete();
      fetchCnt = 0;
      maxAddr  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finishRun(input string name, input bit rndReady);
      int c;
      for (c = 0; c < 2000; c++) begin
         instr_ready = rndReady ? ($urandom_range(0, 9) < 7) : 1'b1;
         tick();
         if (!busy) break;
      end
      instr_ready = 1'b1;
      nChk++;
      if (busy) begin
         nFail++;
         $display("FAIL %s_timeout: busy=%b want 0", name, busy);
      end
   endtask

   task automatic compareRun(input string name);
      buildModel();
      nChk++;
      if (obsQ.size() !== expQ.size()) begin
         nFail++;
         $display("FAIL %s_len: got %0d want %0d",
                  name, obsQ.size(), expQ.size());
      end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         nChk++;
         if (obsQ[i] !== expQ[i]) begin
            nFail++;
            $display("FAIL %s_word%0d: got %h want %h",
                     name, i, obsQ[i], expQ[i]);
         end
      end
      nChk++;
      if ({halted, op_err} !== {expHalt, expErr}) begin
         nFail++;
         $display("FAIL %s_flags: halted/op_err got %b%b want %b%b",
                  name, halted, op_err, expHalt, expErr);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      nChk++;
      if ({imem_en, imem_addr, instr_valid, instr, instr_pc,
           busy, halted, op_err} !== 37'd0) begin
         nFail++;
         $display("FAIL reset_outputs: en=%b addr=%h v=%b i=%h pc=%h b=%b h=%b e=%b want all 0",
                  imem_en, imem_addr, instr_valid, instr, instr_pc,
                  busy, halted, op_err);
      end
      nChk++;
      if (wAddr !== 4'd14 || wValid !== 1'b0 || wBusy !== 1'b0) begin
         nFail++;
         $display("FAIL reset_wrap: addr=%0d v=%b b=%b want 14 0 0",
                  wAddr, wValid, wBusy);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      mem[0] = 16'h1123;
      mem[1] = 16'h2456;
      mem[2] = 16'h4789;
      mem[3] = 16'hB000;
      mem[4] = 16'h1111;
      instr_ready = 1'b1;
      startRun();
      nChk++;
      if (imem_en !== 1'b1 || imem_addr !== 8'd0) begin
         nFail++;
         $display("FAIL basic_c1_fetch: en=%b addr=%h want 1 00",
                  imem_en, imem_addr);
      end
      tick();
      nChk++;
      if (instr_valid !== 1'b0) begin
         nFail++;
         $display("FAIL basic_c2_valid: got %b want 0", instr_valid);
      end
      tick();
      nChk++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h1123, 8'd0}) begin
         nFail++;
         $display("FAIL basic_c3_issue: v=%b i=%h pc=%h want 1 1123 00",
                  instr_valid, instr, instr_pc);
      end
      tick();
      tick();
      tick();
      nChk++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hB000, 8'd3}) begin
         nFail++;
         $display("FAIL basic_c6_halt: v=%b i=%h pc=%h want 1 b000 03",
                  instr_valid, instr, instr_pc);
      end
      tick();
      nChk++;
      if ({halted, busy, instr_valid} !== 3'b100) begin
         nFail++;
         $display("FAIL basic_c7_halted: h=%b b=%b v=%b want 1 0 0",
                  halted, busy, instr_valid);
      end
      tick();
      tick();
      nChk++;
      if (maxAddr !== 4 || fetchCnt !== 5) begin
         nFail++;
         $display("FAIL basic_fetches: max=%0d n=%0d want 4 5",
                  maxAddr, fetchCnt);
      end
      compareRun("basic");
   endtask

`ifdef NN_ISSUE_CNT_EN
   task automatic test_issue_cnt();
      nChk++;
      if (issueCnt !== 16'd4) begin
         nFail++;
         $display("FAIL cnt_after_run: got %0d want 4", issueCnt);
      end
      startRun();
      nChk++;
      if (issueCnt !== 16'd0) begin
         nFail++;
         $display("FAIL cnt_cleared: got %0d want 0", issueCnt);
      end
      tick();
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      finishRun("cnt", 1'b0);
      nChk++;
      if (issueCnt !== 16'd4) begin
         nFail++;
         $display("FAIL cnt_start_in_run: got %0d want 4", issueCnt);
      end
      compareRun("cnt");
   endtask
`endif

   task automatic test_backpressure();
      int c;
      for (int i = 0; i < 8; i++) mem[i] = randLegal();
      mem[8] = 16'hB123;
      buildModel();
      instr_ready = 1'b0;
      startRun();
      for (c = 0; c < 10 && !instr_valid; c++) tick();
      nChk++;
      if (!instr_valid) begin
         nFail++;
         $display("FAIL bp_first_valid: got %b want 1", instr_valid);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         nChk++;
         if ({instr, instr_pc} !== expQ[0]) begin
            nFail++;
            $display("FAIL bp_stable%0d: got %h want %h",
                     i, {instr, instr_pc}, expQ[0]);
         end
      end
      nChk++;
      if (imem_en !== 1'b0 || fetchCnt !== 4) begin
         nFail++;
         $display("FAIL bp_full: en=%b fetches=%0d want 0 4",
                  imem_en, fetchCnt);
      end
      finishRun("bp", 1'b0);
      compareRun("bp");
   endtask

   task automatic test_invalid();
      mem[0] = 16'h1123;
      mem[1] = 16'h2456;
      mem[2] = 16'h5000;
      mem[3] = 16'h1777;
      mem[4] = 16'hB000;
      startRun();
      finishRun("inv", 1'b0);
      compareRun("inv");
      nChk++;
      if ({halted, op_err, busy} !== 3'b010) begin
         nFail++;
         $display("FAIL inv_status: h=%b e=%b b=%b want 0 1 0",
                  halted, op_err, busy);
      end
   endtask

   task automatic test_wrap();
      int c;
      logic [3:0] want [4];
      want = '{4'd14, 4'd15, 4'd0, 4'd1};
      wMem[14] = 16'h1abc;
      wMem[15] = 16'h2def;
      wMem[0]  = 16'h3012;
      wMem[1]  = 16'hB000;
      wMem[2]  = 16'h4444;
      wObsQ.delete();
      wReady = 1'b1;
      wStart = 1'b1;
      tick();
      wStart = 1'b0;
      for (c = 0; c < 50 && !wHalted; c++) tick();
      nChk++;
      if (!wHalted || wObsQ.size() != 4) begin
         nFail++;
         $display("FAIL wrap_done: halted=%b n=%0d want 1 4",
                  wHalted, wObsQ.size());
      end
      for (int i = 0; i < 4 && i < wObsQ.size(); i++) begin
         nChk++;
         if (wObsQ[i] !== want[i]) begin
            nFail++;
            $display("FAIL wrap_pc%0d: got %0d want %0d",
                     i, wObsQ[i], want[i]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 10; i++) mem[i] = randLegal();
      mem[10] = 16'hB000;
      instr_ready = 1'b0;
      startRun();
      for (int i = 0; i < 8; i++) tick();
      nChk++;
      if (instr_valid !== 1'b1 || fetchCnt !== 4) begin
         nFail++;
         $display("FAIL rst_pre_full: v=%b fetches=%0d want 1 4",
                  instr_valid, fetchCnt);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      nChk++;
      if ({instr_valid, busy, imem_en, imem_addr} !== 11'd0) begin
         nFail++;
         $display("FAIL rst_mid: v=%b b=%b en=%b addr=%h want 0 0 0 00",
                  instr_valid, busy, imem_en, imem_addr);
      end
      instr_ready = 1'b1;
      tick();
      startRun();
      finishRun("rst", 1'b1);
      compareRun("rst");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 5) == 0) ?
                     16'($urandom) : randLegal();
         end
         mem[40] = 16'hB000;
         startRun();
         finishRun("rnd", 1'b1);
         compareRun($sformatf("rnd%0d", r));
      end
   endtask

   initial begin
      start       = 1'b0;
      instr_ready = 1'b1;
      wStart      = 1'b0;
      wReady      = 1'b1;
      fetchCnt    = 0;
      maxAddr     = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'hB000;
      for (int i = 0; i < 16; i++) wMem[i] = 16'hB000;
      test_reset();
      test_basic();
`ifdef NN_ISSUE_CNT_EN
      test_issue_cnt();
`endif
      test_backpressure();
      test_invalid();
      test_wrap();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule
